// File: rtl/sqrt_pkg.sv
// Shared constants and FSM encoding for the SQRT result formatter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sqrt_pkg;

    localparam int Q_INT_W         = 8;
    localparam int Q_FRAC_W        = 8;
    localparam int Q_W             = Q_INT_W + Q_FRAC_W;
    localparam int BCD_INT_DIGITS  = 3;
    localparam int BCD_FRAC_DIGITS = 2;
    localparam int BCD_INT_W       = 4 * BCD_INT_DIGITS;
    localparam int BCD_FRAC_W      = 4 * BCD_FRAC_DIGITS;
    localparam int INT_STEPS       = 8;
    localparam int FRAC_STEPS      = 2;

    typedef enum logic [1:0] {
        IDLE,
        INT,
        FRAC,
        FIN
    } fmt_state_t;

endpackage

// File: rtl/sqrt_bcd_fmt_if.sv
// Request/result bundle between the SQRT unit and the BCD formatter.
// Latency: n/a (wires only).
// Backpressure: START is only honoured while BUSY is low.
interface sqrt_bcd_fmt_if;
    import sqrt_pkg::*;

    logic                  START;
    logic [Q_W-1:0]        DATA_IN;
    logic                  BUSY;
    logic                  DONE;
    logic [BCD_INT_W-1:0]  BCD_INT;
    logic [BCD_FRAC_W-1:0] BCD_FRAC;

    modport master (
        output START, DATA_IN,
        input  BUSY, DONE, BCD_INT, BCD_FRAC
    );

    modport slave (
        input  START, DATA_IN,
        output BUSY, DONE, BCD_INT, BCD_FRAC
    );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 before the shift.
// Latency: combinational.
// Backpressure: none.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // correct one BCD digit so the following left shift carries at ten
    always_comb begin
        dout = (din >= 4'd5) ? (din + 4'd3) : din;
    end

endmodule

// File: rtl/sqrt_bcd_fmt.sv
// Converts an unsigned Q8.8 value into 3 integer + 2 truncated fraction BCD digits.
// Latency: DONE 11 cycles after the accepting edge; one conversion per 12 cycles.
// Backpressure: START is ignored while BUSY; results hold until the next completion.
module sqrt_bcd_fmt
    import sqrt_pkg::*;
(
    input  logic           CLK,
    input  logic           RST,
    sqrt_bcd_fmt_if.slave  bus
);

    fmt_state_t            state;
    fmt_state_t            state_nxt;
    logic [2:0]            step_cnt;
    logic [Q_INT_W-1:0]    int_sr;
    logic [Q_FRAC_W-1:0]   frac_r;
    logic [BCD_INT_W-1:0]  bcd_acc;
    logic [BCD_INT_W-1:0]  bcd_adj;
    logic [BCD_FRAC_W-1:0] frac_bcd;
    logic [11:0]           frac_x10;
    logic                  last_int;
    logic                  last_frac;

    // one +3 corrector per integer digit of the accumulator
    for (genvar d = 0; d < BCD_INT_DIGITS; d++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (bcd_acc[4*d +: 4]),
            .dout (bcd_adj[4*d +: 4])
        );
    end

    // fraction times ten by shift-add; the top nibble is the next decimal digit
    always_comb begin
        frac_x10  = ({4'd0, frac_r} << 3) + ({4'd0, frac_r} << 1);
        last_int  = (step_cnt == 3'(INT_STEPS - 1));
        last_frac = (step_cnt == 3'(FRAC_STEPS - 1));
    end

    // state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state: fixed walk IDLE -> INT x8 -> FRAC x2 -> FIN -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.START) state_nxt = INT;
            INT:     if (last_int)  state_nxt = FRAC;
            FRAC:    if (last_frac) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // datapath, step counter and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            step_cnt     <= '0;
            int_sr       <= '0;
            frac_r       <= '0;
            bcd_acc      <= '0;
            frac_bcd     <= '0;
            bus.BUSY     <= 1'b0;
            bus.DONE     <= 1'b0;
            bus.BCD_INT  <= '0;
            bus.BCD_FRAC <= '0;
        end else begin
            bus.DONE <= (state == FIN);
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        int_sr   <= bus.DATA_IN[Q_W-1:Q_FRAC_W];
                        frac_r   <= bus.DATA_IN[Q_FRAC_W-1:0];
                        bcd_acc  <= '0;
                        frac_bcd <= '0;
                        step_cnt <= '0;
                        bus.BUSY <= 1'b1;
                    end
                end
                INT: begin
                    {bcd_acc, int_sr} <= {bcd_adj, int_sr} << 1;
                    step_cnt <= last_int ? 3'd0 : (step_cnt + 3'd1);
                end
                FRAC: begin
                    frac_bcd <= {frac_bcd[3:0], frac_x10[11:8]};
                    frac_r   <= frac_x10[7:0];
                    step_cnt <= step_cnt + 3'd1;
                end
                FIN: begin
                    bus.BCD_INT  <= bcd_acc;
                    bus.BCD_FRAC <= frac_bcd;
                    bus.BUSY     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_bcd_fmt.sv
// Bench for sqrt_bcd_fmt: decimal-arithmetic reference model checked every cycle.
// Latency: model completes 11 edges after the accepting edge.
// Backpressure: model drops START while a conversion is outstanding.
module tb_sqrt_bcd_fmt;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    sqrt_bcd_fmt_if bus ();

    sqrt_bcd_fmt dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // reference: integer via /100, /10, %10; fraction = floor(f*100/256)
    function automatic logic [19:0] fmt(input logic [15:0] v);
        int i;
        int q;
        i = int'(v[15:8]);
        q = (int'(v[7:0]) * 100) / 256;
        return {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10), 4'(q / 10), 4'(q % 10)};
    endfunction

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [11:0] m_int  = '0;
    logic [7:0]  m_frac = '0;
    logic [15:0] m_val  = '0;
    int          m_cnt  = 0;

    // behavioural model: accept when idle, finish 11 edges later
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_int  = '0;
            m_frac = '0;
            m_cnt  = 0;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                {m_int, m_frac} = fmt(m_val);
            end else begin
                m_cnt  = m_cnt - 1;
                m_done = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            if (bus.START) begin
                m_busy = 1'b1;
                m_val  = bus.DATA_IN;
                m_cnt  = 10;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // advance one cycle and compare every output against the model
    task automatic tick();
        @(negedge CLK);
        chk("busy", int'(bus.BUSY), int'(m_busy));
        chk("done", int'(bus.DONE), int'(m_done));
        chk("bcd_int", int'(bus.BCD_INT), int'(m_int));
        chk("bcd_frac", int'(bus.BCD_FRAC), int'(m_frac));
    endtask

    // issue one conversion and check latency, BUSY width and literal result
    task automatic convert(input logic [15:0] v, input logic [11:0] ei, input logic [7:0] ef);
        int lat;
        int busy_n;
        bus.START   = 1'b1;
        bus.DATA_IN = v;
        tick();
        bus.START   = 1'b0;
        bus.DATA_IN = 16'($urandom);
        chk("accept_busy", int'(bus.BUSY), 1);
        lat    = 0;
        busy_n = 1;
        while (!bus.DONE && lat < 30) begin
            tick();
            lat++;
            if (bus.BUSY) busy_n++;
        end
        chk("latency", lat, 11);
        chk("busy_cycles", busy_n, 11);
        chk("lit_int", int'(bus.BCD_INT), int'(ei));
        chk("lit_frac", int'(bus.BCD_FRAC), int'(ef));
    endtask

    initial begin
        int n_done;
        bus.START   = 1'b0;
        bus.DATA_IN = '0;
        RST         = 1'b1;
        repeat (3) tick();
        chk("rst_busy", int'(bus.BUSY), 0);
        chk("rst_int", int'(bus.BCD_INT), 0);
        RST = 1'b0;
        tick();

        convert(16'h0000, 12'h000, 8'h00);
        tick();
        convert(16'h0208, 12'h002, 8'h03);
        tick();
        chk("done_width", int'(bus.DONE), 0);

        // back-to-back: second START sits in the DONE cycle of the first
        convert(16'h05F9, 12'h005, 8'h97);
        convert(16'h0A62, 12'h010, 8'h38);
        tick();
        convert(16'hFFFF, 12'h255, 8'h99);
        tick();
        convert(16'h6400, 12'h100, 8'h00);
        tick();

        // START while busy must be dropped
        bus.START   = 1'b1;
        bus.DATA_IN = 16'h1234;
        tick();
        bus.START   = 1'b0;
        repeat (3) tick();
        bus.START   = 1'b1;
        bus.DATA_IN = 16'hC8FF;
        tick();
        bus.START   = 1'b0;
        n_done = 0;
        repeat (25) begin
            tick();
            if (bus.DONE) n_done++;
        end
        chk("ignored_one_done", n_done, 1);
        chk("ignored_int", int'(bus.BCD_INT), 12'h018);
        chk("ignored_frac", int'(bus.BCD_FRAC), 8'h20);

        // reset mid-conversion
        bus.START   = 1'b1;
        bus.DATA_IN = 16'h0A62;
        tick();
        bus.START   = 1'b0;
        repeat (4) tick();
        RST = 1'b1;
        tick();
        chk("abort_busy", int'(bus.BUSY), 0);
        chk("abort_int", int'(bus.BCD_INT), 0);
        chk("abort_frac", int'(bus.BCD_FRAC), 0);
        tick();
        RST = 1'b0;
        n_done = 0;
        repeat (15) begin
            tick();
            if (bus.DONE) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        convert(16'h05F9, 12'h005, 8'h97);
        tick();

        // random traffic, including STARTs that land while busy
        repeat (1500) begin
            bus.START   = ($urandom_range(0, 3) == 0);
            bus.DATA_IN = 16'($urandom);
            tick();
        end
        bus.START = 1'b0;
        repeat (15) tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
